// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute stage of the venus pipeline.
// Single-cycle ALU/branch ops, an iterative restoring divider and a req/ack data-memory port.
module execute_mc #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 16,
  parameter int W_RD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0] dest_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  rd_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_rd_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic [3:0]       status_o,
  output logic             branch_o,
  output logic [ADDR-1:0]  baddr_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ack_i
);
  // state | meaning
  // IDLE  | accepting instructions; single-cycle ops complete here
  // DIV   | restoring divide, one quotient bit per cycle
  // MEM   | memory request outstanding, waiting for ack
  // HALT  | stopped until reset
  localparam logic [1:0] S_IDLE = 2'd0, S_DIV = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                         OP_MUL = 4'h8, OP_DIVU = 4'h9, OP_REMU = 4'hA, OP_LOAD = 4'hB,
                         OP_STORE = 4'hC, OP_JZ = 4'hD, OP_JMP = 4'hE, OP_HALT = 4'hF;

  localparam int SW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             sel_q, sel_d, wben_q, wben_d;
  logic [W_RD-1:0]  rd_q, rd_d;
  logic             wb_q, wb_d, branch_q, branch_d;
  logic [W_RD-1:0]  wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       status_q, status_d;
  logic [ADDR-1:0]  baddr_q, baddr_d, mem_addr_q, mem_addr_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic             accept;
  logic [WIDTH:0]   sum, div_sh;
  logic [WIDTH-1:0] diff, alu_res, div_rem, div_quo, div_res;
  logic             alu_c, alu_v, alu_wr, div_ge;
  logic [3:0]       alu_flg;

  assign stall_o = (state_q != S_IDLE);
  assign accept  = v_i & ~stall_o & ~branch_q;

  always_comb begin
    sum     = {1'b0, dest_i} + {1'b0, src_i};
    diff    = dest_i - src_i;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    case (op_i)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (dest_i[WIDTH-1] == src_i[WIDTH-1]) && (alu_res[WIDTH-1] != dest_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = dest_i < src_i;
        alu_v   = (dest_i[WIDTH-1] != src_i[WIDTH-1]) && (diff[WIDTH-1] != dest_i[WIDTH-1]);
      end
      OP_AND: alu_res = dest_i & src_i;
      OP_OR:  alu_res = dest_i | src_i;
      OP_XOR: alu_res = dest_i ^ src_i;
      OP_SHL: alu_res = (src_i >= WIDTH'(WIDTH)) ? '0 : dest_i << src_i[SW-1:0];
      OP_SHR: alu_res = (src_i >= WIDTH'(WIDTH)) ? '0 : dest_i >> src_i[SW-1:0];
      OP_MUL: alu_res = dest_i * src_i;
      default: alu_wr = 1'b0;
    endcase
    // NOP/JZ/JMP land in the default arm and clear every flag
    alu_flg = alu_wr ? {alu_c, alu_v, alu_res[WIDTH-1], alu_res == '0} : 4'b0000;
  end

  always_comb begin
    div_sh  = {rem_q, quo_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, dvs_q};
    div_rem = div_ge ? div_sh[WIDTH-1:0] - dvs_q : div_sh[WIDTH-1:0];
    div_quo = {quo_q[WIDTH-2:0], div_ge};
    div_res = sel_q ? div_rem : div_quo;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sel_d       = sel_q;
    wben_d      = wben_q;
    rd_d        = rd_q;
    wb_d        = 1'b0;
    branch_d    = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    status_d    = status_q;
    baddr_d     = baddr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        rd_d   = rd_i;
        wben_d = wb_i;
        case (op_i)
          OP_DIVU, OP_REMU: begin
            state_d = S_DIV;
            cnt_d   = SW'(WIDTH - 1);
            rem_d   = '0;
            quo_d   = dest_i;
            dvs_d   = src_i;
            sel_d   = (op_i == OP_REMU);
          end
          OP_LOAD, OP_STORE: begin
            state_d    = S_MEM;
            mem_req_d  = 1'b1;
            mem_we_d   = (op_i == OP_STORE);
            mem_addr_d = src_i[ADDR-1:0];
            sel_d      = (op_i == OP_LOAD);
            if (op_i == OP_STORE) mem_wdata_d = dest_i;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            status_d = alu_flg;
            if (wb_i && alu_wr) begin
              wb_d      = 1'b1;
              wb_rd_d   = rd_i;
              wb_data_d = alu_res;
            end
            // JZ tests the flags as they stood before this instruction
            if (op_i == OP_JMP || (op_i == OP_JZ && status_q[0])) begin
              branch_d = 1'b1;
              baddr_d  = src_i[ADDR-1:0];
            end
          end
        endcase
      end
      S_DIV: begin
        rem_d = div_rem;
        quo_d = div_quo;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          state_d   = S_IDLE;
          status_d  = {1'b0, dvs_q == '0, div_res[WIDTH-1], div_res == '0};
          wb_d      = wben_q;
          if (wben_q) begin
            wb_rd_d   = rd_q;
            wb_data_d = div_res;
          end
        end
      end
      S_MEM: if (mem_ack_i && mem_req_q) begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        status_d  = 4'b0000;
        if (sel_q) begin
          status_d = {2'b00, mem_rdata_i[WIDTH-1], mem_rdata_i == '0};
          wb_d     = wben_q;
          if (wben_q) begin
            wb_rd_d   = rd_q;
            wb_data_d = mem_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sel_q       <= 1'b0;
      wben_q      <= 1'b0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      branch_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      status_q    <= '0;
      baddr_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sel_q       <= sel_d;
      wben_q      <= wben_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      branch_q    <= branch_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      status_q    <= status_d;
      baddr_q     <= baddr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign wb_o        = wb_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign status_o    = status_q;
  assign branch_o    = branch_q;
  assign baddr_o     = baddr_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_execute_mc.sv
// Testbench for execute_mc: constant vectors, random ops against an arithmetic model,
// and directed sequences for memory, squash, reset and halt.
module tb_execute_mc;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          v_i = 1'b0, wb_i = 1'b0, mem_ack_i = 1'b0;
  logic [3:0]    op_i = '0;
  logic [W-1:0]  src_i = '0, dest_i = '0, mem_rdata_i = '0;
  logic [2:0]    rd_i = '0;
  logic          stall_o, wb_o, branch_o, mem_req_o, mem_we_o;
  logic [2:0]    wb_rd_o;
  logic [W-1:0]  wb_data_o, baddr_o, mem_addr_o, mem_wdata_o;
  logic [3:0]    status_o;

  execute_mc #(.WIDTH(16), .ADDR(16), .W_RD(3)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .op_i(op_i),
    .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .rd_i(rd_i),
    .wb_o(wb_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .status_o(status_o),
    .branch_o(branch_o), .baddr_o(baddr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] d;
    logic [15:0] s;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t tv [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one instruction and wait out any stall; returns the number of stalled cycles.
  task automatic exec(input logic [3:0] op, input logic [15:0] d, input logic [15:0] s,
                      input logic wb, input logic [2:0] rd, output int cyc);
    int guard = 0;
    while ((stall_o || branch_o) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op_i = op; dest_i = d; src_i = s; wb_i = wb; rd_i = rd; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    cyc = 0;
    while (stall_o && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ctl"}, 32'({stall_o, wb_o, branch_o, mem_req_o, mem_we_o}), 32'd0);
    check({tag, "_wb"}, 32'({wb_rd_o, wb_data_o}), 32'd0);
    check({tag, "_status"}, 32'(status_o), 32'd0);
    check({tag, "_addr"}, 32'({baddr_o, mem_addr_o}), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [15:0] d, input logic [15:0] s,
                                input logic [3:0] fin, output logic [15:0] r,
                                output logic [3:0] fo, output logic wr, output logic br);
    longint a, b, t, sa, sb;
    logic c, v;
    a = longint'(d); b = longint'(s);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c = 1'b0; v = 1'b0; t = 0; wr = 1'b1; br = 1'b0;
    case (op)
      4'h1: begin t = a + b; c = (t > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'h2: begin t = a - b; c = (a < b);     v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'h3: t = a & b;
      4'h4: t = a | b;
      4'h5: t = a ^ b;
      4'h6: t = (b >= 16) ? 0 : a * (longint'(1) << b);
      4'h7: t = (b >= 16) ? 0 : a / (longint'(1) << b);
      4'h8: t = a * b;
      4'h9: begin t = (b == 0) ? 65535 : a / b; v = (b == 0); end
      4'hA: begin t = (b == 0) ? a : a % b;     v = (b == 0); end
      default: begin wr = 1'b0; br = (op == 4'hE) || (op == 4'hD && fin[0]); end
    endcase
    r = 16'(t % 65536);
    fo = wr ? {c, v, (r >= 16'h8000), (r == 16'h0000)} : 4'b0000;
  endfunction

  initial begin
    int cyc, hi, wbs;
    logic [3:0]  op, mf, ef;
    logic [15:0] d, s, er;
    logic [2:0]  rd;
    logic        wb, ewr, ebr;

    tv[0]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
    tv[1]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
    tv[2]  = '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
    tv[3]  = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
    tv[4]  = '{4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    tv[5]  = '{4'h4, 16'h0000, 16'h0000, 16'h0000, 4'b0001};
    tv[6]  = '{4'h5, 16'hFFFF, 16'h7FFF, 16'h8000, 4'b0010};
    tv[7]  = '{4'h6, 16'h0001, 16'h000F, 16'h8000, 4'b0010};
    tv[8]  = '{4'h6, 16'h1234, 16'h0010, 16'h0000, 4'b0001};
    tv[9]  = '{4'h7, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
    tv[10] = '{4'h7, 16'hFFFF, 16'h0100, 16'h0000, 4'b0001};
    tv[11] = '{4'h8, 16'h0100, 16'h0100, 16'h0000, 4'b0001};
    tv[12] = '{4'h8, 16'h00FF, 16'h00FF, 16'hFE01, 4'b0010};
    tv[13] = '{4'h9, 16'd100,  16'd7,    16'd14,   4'b0000};
    tv[14] = '{4'hA, 16'd100,  16'd7,    16'd2,    4'b0000};
    tv[15] = '{4'h9, 16'h1234, 16'h0000, 16'hFFFF, 4'b0110};
    tv[16] = '{4'hA, 16'h1234, 16'h0000, 16'h1234, 4'b0100};
    tv[17] = '{4'h9, 16'hFFFF, 16'h0001, 16'hFFFF, 4'b0010};
    tv[18] = '{4'hA, 16'd5,    16'd9,    16'd5,    4'b0000};
    tv[19] = '{4'h9, 16'd5,    16'd9,    16'd0,    4'b0001};

    #12;
    chk_reset("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // random phase: flags start at zero out of reset
    mf = 4'b0000;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 12));
      if (op > 4'hA) op = op + 4'h2;
      d  = 16'($urandom);
      s  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) s = 16'h0000;
      wb = 1'($urandom);
      rd = 3'($urandom);
      model(op, d, s, mf, er, ef, ewr, ebr);
      exec(op, d, s, wb, rd, cyc);
      check("rnd_latency", 32'(cyc), (op == 4'h9 || op == 4'hA) ? 32'd16 : 32'd0);
      check("rnd_wb", 32'(wb_o), 32'(wb & ewr));
      if (wb & ewr) check("rnd_data", 32'({wb_rd_o, wb_data_o}), 32'({rd, er}));
      check("rnd_status", 32'(status_o), 32'(ef));
      check("rnd_branch", 32'(branch_o), 32'(ebr));
      if (ebr) check("rnd_baddr", 32'(baddr_o), 32'(s));
      mf = ef;
    end

    for (int i = 0; i < 20; i++) begin
      exec(tv[i].op, tv[i].d, tv[i].s, 1'b1, 3'(i), cyc);
      check("vec_latency", 32'(cyc), (tv[i].op == 4'h9 || tv[i].op == 4'hA) ? 32'd16 : 32'd0);
      check("vec_wb", 32'({wb_o, wb_rd_o}), 32'({1'b1, 3'(i)}));
      check("vec_data", 32'(wb_data_o), 32'(tv[i].r));
      check("vec_status", 32'(status_o), 32'(tv[i].f));
    end

    // LOAD with three wait cycles, ack on the fourth
    exec(4'h0, 16'h0, 16'h0, 1'b0, 3'd0, cyc);
    op_i = 4'hB; src_i = 16'h0040; dest_i = 16'h0; wb_i = 1'b1; rd_i = 3'd5; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("load_hold", 32'({stall_o, mem_req_o, mem_we_o, mem_addr_o}), 32'({3'b110, 16'h0040}));
      if (k == 3) begin mem_ack_i = 1'b1; mem_rdata_i = 16'hBEEF; end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    check("load_done", 32'({stall_o, mem_req_o, wb_o, wb_rd_o}), 32'({3'b001, 3'd5}));
    check("load_data", 32'(wb_data_o), 32'h0000BEEF);
    check("load_status", 32'(status_o), 32'b0010);

    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    check("stray_ack", 32'({stall_o, mem_req_o, wb_o}), 32'd0);

    op_i = 4'hC; src_i = 16'h0010; dest_i = 16'h0055; wb_i = 1'b1; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    check("store_req", 32'({mem_req_o, mem_we_o, mem_addr_o}), 32'({2'b11, 16'h0010}));
    check("store_wdata", 32'(mem_wdata_o), 32'h55);
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    check("store_done", 32'({stall_o, mem_req_o, wb_o, status_o}), 32'd0);

    // SUB to set Z, JZ taken, ADD behind it squashed
    exec(4'h2, 16'd5, 16'd5, 1'b1, 3'd1, cyc);
    check("sub_z", 32'(status_o), 32'b0001);
    op_i = 4'hD; src_i = 16'h0100; wb_i = 1'b0; v_i = 1'b1;
    @(posedge clk); #1;
    op_i = 4'h1; dest_i = 16'h7FFF; src_i = 16'h0001; wb_i = 1'b1; rd_i = 3'd2;
    check("jz_branch", 32'({branch_o, wb_o, baddr_o}), 32'({2'b10, 16'h0100}));
    check("jz_flags", 32'(status_o), 32'd0);
    @(posedge clk); #1;
    v_i = 1'b0;
    check("squash", 32'({branch_o, wb_o, status_o}), 32'd0);

    // reset mid-DIV
    op_i = 4'h9; dest_i = 16'd100; src_i = 16'd7; wb_i = 1'b1; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1 chk_reset("rst_div");
    #2 rst = 1'b1;
    @(posedge clk); #1;
    exec(4'h1, 16'd2, 16'd3, 1'b1, 3'd4, cyc);
    check("after_rst_div", 32'({cyc[3:0], wb_o, wb_data_o}), 32'({4'd0, 1'b1, 16'd5}));

    // reset mid-MEM
    op_i = 4'hC; dest_i = 16'hA5A5; src_i = 16'h0022; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1 chk_reset("rst_mem");
    #2 rst = 1'b1;
    @(posedge clk); #1;
    exec(4'h5, 16'h00F0, 16'h0F00, 1'b1, 3'd6, cyc);
    check("after_rst_mem", 32'({cyc[3:0], wb_o, wb_data_o}), 32'({4'd0, 1'b1, 16'h0FF0}));

    // HALT holds stall_o and blocks further instructions
    op_i = 4'hF; v_i = 1'b1;
    @(posedge clk); #1;
    op_i = 4'h1; dest_i = 16'd1; src_i = 16'd1; wb_i = 1'b1;
    hi = 0; wbs = 0;
    repeat (30) begin
      if (stall_o) hi++;
      if (wb_o) wbs++;
      @(posedge clk); #1;
    end
    v_i = 1'b0;
    check("halt_stall", 32'(hi), 32'd30);
    check("halt_no_wb", 32'(wbs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised multi-cycle execute stage for the venus pipeline, the last stage after ID. It adds an iterative unsigned divider, load/store through a req/ack data-memory port, registered branch outputs with squash of the following slot, and a registered writeback to the register file. It keeps the status flags, and stalls ID through a registered `stall_o` while a multi-cycle op or halt is in progress.

## Interface
- `WIDTH`, 16: data word width (≥4, power of 2)
- `ADDR`, 16: instruction/data address width (≤ WIDTH)
- `W_RD`, 3: register-name width
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `v_i` in 1: ID presents a valid instruction
- `stall_o` out 1: EX cannot accept; ID holds its instruction
- `op_i` in 4: opcode (see Operation)
- `src_i`, `dest_i` in WIDTH: operands
- `wb_i` in 1: instruction writes `rd_i`
- `rd_i` in W_RD: destination register name
- `wb_o` out 1: one-cycle writeback strobe
- `wb_rd_o` out W_RD: writeback register name
- `wb_data_o` out WIDTH: writeback data
- `status_o` out 4: flags {C,V,N,Z}
- `branch_o` out 1: one-cycle redirect strobe to IF
- `baddr_o` out ADDR: redirect target
- `mem_req_o` out 1: memory request, held until ack
- `mem_we_o` out 1: 1 = store
- `mem_addr_o` out ADDR: memory address
- `mem_wdata_o` out WIDTH: store data
- `mem_rdata_i` in WIDTH: load data, valid with ack
- `mem_ack_i` in 1: request complete

## Operation
- Accept: rising edge with `v_i & ~stall_o & ~branch_o`. An instruction presented while `branch_o`=1 is squashed: no state change and no outputs.
- `stall_o` = (state ≠ IDLE) | halt_r. It is decoded only from registers, with no combinational path from `v_i`.
- States: IDLE, DIV, MEM, HALT.
- Result is dest op src.
  - Ops: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 SHL and 7 SHR (logical): shift dest by src; src ≥ WIDTH gives 0.
  - 8 MUL: low WIDTH bits.
  - 9 DIVU (quotient), A REMU (remainder).
  - B LOAD: addr = src[ADDR-1:0].
  - C STORE: addr = src, data = dest.
  - D JZ: target = src[ADDR-1:0], taken if status Z=1.
  - E JMP: target = src. F HALT.
- Single-cycle ops (0–8, D, E) complete at the accept edge.
- DIV: restoring, one quotient bit per cycle, WIDTH iterations.
- MEM: `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are registered at accept and held stable until `mem_ack_i` is sampled high. At that edge `mem_req_o` drops and the state returns to IDLE.
- Writeback: `wb_o`=1 for one cycle only for ops 1–A and B with `wb_i`=1. `wb_rd_o`/`wb_data_o` hold their last value otherwise.
- Flags, updated at completion:
  - ADD/SUB set all four. C = carry out (ADD) or borrow, dest<src unsigned (SUB). V = signed overflow.
  - AND–MUL, DIVU, REMU, LOAD: set N, Z; clear C, V.
  - NOP, STORE, JMP, JZ: clear all flags. JZ evaluates Z before clearing.
- Divide by zero: quotient all-ones, remainder = dest, V=1 (N, Z from result). Same latency as a normal divide.
- HALT: enter HALT and stay there until reset; `stall_o` stays 1.
- Reset: state IDLE. All outputs are 0 asynchronously: `stall_o`, `wb_o`, `wb_rd_o`, `wb_data_o`, `status_o`, `branch_o`, `baddr_o`, `mem_*`. An in-flight divide or memory request is abandoned.

## Timing
- Single-cycle op accepted at edge E0: `wb_o`/`status_o` valid in the cycle after E0. `branch_o`/`baddr_o` follow the same timing and pulse for exactly one cycle.
- DIVU/REMU accepted at E0: iterations at E1..E_WIDTH. `wb_o` is high in the cycle after E_WIDTH. `stall_o` is high in cycles E0..E_WIDTH−1 (WIDTH cycles). The next instruction can be accepted at E_WIDTH+1.
- LOAD/STORE accepted at E0: `mem_req_o` is high from after E0. If ack is first sampled at edge Ek (k≥1), completion and writeback happen at Ek. `stall_o` is high until Ek.
- Ack sampled while `mem_req_o`=0 is ignored.
- `branch_o` is never raised for a squashed slot. Back-to-back jumps need an intervening bubble.

## Test plan
- ADD with WIDTH=16, dest=0x7FFF, src=0x0001: cycle after accept gives `wb_o`=1, data 0x8000, flags C=0 V=1 N=1 Z=0.
- DIVU dest=100, src=7 (WIDTH=16): `stall_o` is high for 16 cycles, then `wb_data_o`=14. REMU of the same operands gives 2. The next instruction is accepted on the following edge.
- DIVU dest=0x1234, src=0: quotient 0xFFFF, V=1. REMU of the same operands gives 0x1234. Latency is identical to a normal divide.
- LOAD src=0x0040, with ack after 3 wait cycles returning 0xBEEF: `mem_req_o` and `mem_addr_o`=0x0040 stay stable for 4 cycles, then `wb_data_o`=0xBEEF with Z=0. STORE dest=0x55 gives `mem_we_o`=1 and `mem_wdata_o`=0x55.
- SUB 5−5 (Z=1), then JZ src=0x0100 with an ADD presented behind it: `branch_o`=1, `baddr_o`=0x0100, the ADD is squashed with no `wb_o`, and flags are cleared.
- HALT accepted: `stall_o` stays 1 indefinitely. Drop `rst` mid-DIV and mid-MEM: all outputs are 0 immediately, and after release `stall_o`=0 and a new op is accepted.
